// File: rtl/pc_seq.sv
// ---------------------------------------------------------------------------
// pc_seq - program-counter sequencer for the multi-cycle MIPS core.
//
// Every instruction takes PHASES unstalled clocks. An internal phase counter
// runs 0..PHASES-1. The PC commits once per instruction, on the clock where
// the phase wraps. A redirect (branch, region jump or register jump) may be
// requested at any unstalled clock of the instruction. It is held pending
// until the commit edge, and the last request wins. The sequencer also
// produces the instruction-memory fetch enable.
//
// Parameters:
//   ADDR_W      PC width in bits
//   OFF_W       branch/jump byte-offset width (two's complement for branch)
//   PHASES      clocks per instruction, 2..16
//   FETCH_PHASE phase at which fetch_en asserts, < PHASES
//   RESET_PC    word-aligned PC loaded on reset
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   stall        freezes phase, pc and pending redirect; blocks capture
//   redir_valid  redirect request strobe
//   redir_type   01 branch rel, 10 region jump, 11 register jump, 00 ignored
//   offset       byte offset for types 01/10
//   target       absolute target for type 11
//   pc           current instruction address
//   phase        current phase
//   fetch_en     (phase == FETCH_PHASE) & ~stall
//   instr_done   one-cycle pulse after each commit edge
//   redir_ack    one-cycle pulse with instr_done when a redirect was taken
// ---------------------------------------------------------------------------
module pc_seq #(
  parameter int                ADDR_W      = 32,
  parameter int                OFF_W       = 18,
  parameter int                PHASES      = 4,
  parameter int                FETCH_PHASE = 1,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redir_valid,
  input  logic [1:0]        redir_type,
  input  logic [OFF_W-1:0]  offset,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        phase,
  output logic              fetch_en,
  output logic              instr_done,
  output logic              redir_ack
);

  localparam logic [3:0]        LAST_PHASE = 4'(PHASES - 1);
  localparam logic [3:0]        FETCH_IDX  = 4'(FETCH_PHASE);
  localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [ADDR_W-1:0] pend_pc;
  logic              pend_valid;
  logic [ADDR_W-1:0] branch_tgt;
  logic [ADDR_W-1:0] region_tgt;
  logic [ADDR_W-1:0] raw_tgt;
  logic [ADDR_W-1:0] redir_tgt;
  logic              capture;
  logic              commit;

  // Target is computed from the pc in effect at the capture edge. The
  // bottom two bits are cleared for every type so the PC stays word aligned.
  always_comb begin
    branch_tgt = pc + {{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset};
    region_tgt = {pc[ADDR_W-1:OFF_W], offset};
    case (redir_type)
      2'b01:   raw_tgt = branch_tgt;
      2'b10:   raw_tgt = region_tgt;
      default: raw_tgt = target;
    endcase
    redir_tgt = raw_tgt & ALIGN_MASK;
  end

  assign capture  = ~stall & redir_valid & (redir_type != 2'b00);
  assign commit   = ~stall & (phase == LAST_PHASE);
  assign fetch_en = (phase == FETCH_IDX) & ~stall;

  // A request that arrives on the commit edge itself is newer than anything
  // pending, so it takes priority. The pending flag is cleared on every
  // commit. That way each redirect applies to exactly one instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      phase      <= '0;
      pend_pc    <= '0;
      pend_valid <= 1'b0;
      instr_done <= 1'b0;
      redir_ack  <= 1'b0;
    end else begin
      instr_done <= commit;
      redir_ack  <= commit & (capture | pend_valid);
      if (!stall) begin
        phase <= (phase == LAST_PHASE) ? 4'd0 : phase + 4'd1;
      end
      if (commit) begin
        if (capture) begin
          pc <= redir_tgt;
        end else if (pend_valid) begin
          pc <= pend_pc;
        end else begin
          pc <= pc + WORD_STEP;
        end
        pend_valid <= 1'b0;
      end else if (capture) begin
        pend_pc    <= redir_tgt;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// ---------------------------------------------------------------------------
// tb_pc_seq - self-checking bench for pc_seq (default parameters).
// A table of instructions, each with up to two redirect requests, is run in
// sequence. The expected commit result of each instruction is queued when
// the instruction starts. A monitor pops it on every instr_done pulse.
// Hand-written sequences cover stall freezing and reset with a pending
// redirect.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pc_seq;

  localparam int          ADDR_W      = 32;
  localparam int          OFF_W       = 18;
  localparam int          PHASES      = 4;
  localparam int          FETCH_PHASE = 1;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int          NVEC        = 19;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redir_valid = 1'b0;
  logic [1:0]  redir_type = 2'b00;
  logic [17:0] offset = '0;
  logic [31:0] target = '0;
  logic [31:0] pc;
  logic [3:0]  phase;
  logic        fetch_en;
  logic        instr_done;
  logic        redir_ack;

  always #5 clk = ~clk;

  pc_seq #(
    .ADDR_W(ADDR_W), .OFF_W(OFF_W), .PHASES(PHASES),
    .FETCH_PHASE(FETCH_PHASE), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redir_valid(redir_valid), .redir_type(redir_type),
    .offset(offset), .target(target),
    .pc(pc), .phase(phase), .fetch_en(fetch_en),
    .instr_done(instr_done), .redir_ack(redir_ack)
  );

  typedef struct {
    logic [31:0] pc;
    logic        ack;
  } exp_t;

  typedef struct {
    logic [1:0]  type_a;
    logic [17:0] off_a;
    logic [31:0] tgt_a;
    int          ph_a;
    logic [1:0]  type_b;
    logic [17:0] off_b;
    logic [31:0] tgt_b;
    int          ph_b;
    logic [31:0] exp_pc;
    logic        exp_ack;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[NVEC];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] cur_pc;
  logic        after_commit;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] ta, input logic [17:0] oa,
                              input logic [31:0] ga, input int pa,
                              input logic [1:0] tb, input logic [17:0] ob,
                              input logic [31:0] gb, input int pb,
                              input logic [31:0] ep, input logic ea);
    vec_t v;
    v.type_a = ta; v.off_a = oa; v.tgt_a = ga; v.ph_a = pa;
    v.type_b = tb; v.off_b = ob; v.tgt_b = gb; v.ph_b = pb;
    v.exp_pc = ep; v.exp_ack = ea;
    return v;
  endfunction

  task automatic idleInputs();
    redir_valid = 1'b0;
    redir_type  = 2'b00;
    offset      = '0;
    target      = '0;
  endtask

  task automatic driveReq(input logic [1:0] t, input logic [17:0] o,
                          input logic [31:0] g);
    redir_valid = 1'b1;
    redir_type  = t;
    offset      = o;
    target      = g;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one unstalled instruction from phase 0 through its commit edge.
  task automatic applyStimulus(input vec_t v);
    sb.push_back('{v.exp_pc, v.exp_ack});
    for (int i = 0; i < PHASES; i++) begin
      checkOutput("phase", 32'(phase), 32'(i));
      checkOutput("fetch_en", 32'(fetch_en), 32'(i == FETCH_PHASE));
      checkOutput("pc_hold", pc, cur_pc);
      checkOutput("instr_done_timing", 32'(instr_done), 32'(i == 0 && after_commit));
      if (i == v.ph_a)      driveReq(v.type_a, v.off_a, v.tgt_a);
      else if (i == v.ph_b) driveReq(v.type_b, v.off_b, v.tgt_b);
      else                  idleInputs();
      tick();
    end
    idleInputs();
    cur_pc       = v.exp_pc;
    after_commit = 1'b1;
  endtask

  // Scoreboard consumer: every commit pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (redir_ack === 1'b1 && instr_done !== 1'b1)
        checkOutput("ack_without_done", 32'(redir_ack), 32'(0));
      if (instr_done === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("[TB] FAIL unexpected_done: got pulse expected none at %0t", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("commit_pc", pc, e.pc);
          checkOutput("commit_ack", 32'(redir_ack), 32'(e.ack));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = mk(2'b00, 18'h0, 32'h0, -1, 2'b00, 18'h0, 32'h0, -1, 32'h0000_0004, 1'b0);
    vecs[1]  = mk(2'b00, 18'h0, 32'h0, -1, 2'b00, 18'h0, 32'h0, -1, 32'h0000_0008, 1'b0);
    vecs[2]  = mk(2'b00, 18'h0, 32'h0, -1, 2'b00, 18'h0, 32'h0, -1, 32'h0000_000C, 1'b0);
    vecs[3]  = mk(2'b11, 18'h0, 32'h0000_0100, 3, 2'b00, 18'h0, 32'h0, -1, 32'h0000_0100, 1'b1);
    vecs[4]  = mk(2'b01, 18'h3FFF0, 32'h0, 2, 2'b00, 18'h0, 32'h0, -1, 32'h0000_00F0, 1'b1);
    vecs[5]  = mk(2'b11, 18'h0, 32'h0000_0100, 1, 2'b00, 18'h0, 32'h0, -1, 32'h0000_0100, 1'b1);
    vecs[6]  = mk(2'b01, 18'h00020, 32'h0, 2, 2'b00, 18'h0, 32'h0, -1, 32'h0000_0120, 1'b1);
    vecs[7]  = mk(2'b11, 18'h0, 32'hF000_0040, 0, 2'b00, 18'h0, 32'h0, -1, 32'hF000_0040, 1'b1);
    vecs[8]  = mk(2'b10, 18'h00400, 32'h0, 2, 2'b00, 18'h0, 32'h0, -1, 32'hF000_0400, 1'b1);
    vecs[9]  = mk(2'b11, 18'h0, 32'h1234_5677, 3, 2'b00, 18'h0, 32'h0, -1, 32'h1234_5674, 1'b1);
    vecs[10] = mk(2'b00, 18'h00040, 32'hDEAD_0000, 1, 2'b00, 18'h0, 32'h0, -1, 32'h1234_5678, 1'b0);
    vecs[11] = mk(2'b01, 18'h00007, 32'h0, 1, 2'b00, 18'h0, 32'h0, -1, 32'h1234_567C, 1'b1);
    vecs[12] = mk(2'b01, 18'h00008, 32'h0, 0, 2'b11, 18'h0, 32'h0000_0200, 3, 32'h0000_0200, 1'b1);
    vecs[13] = mk(2'b11, 18'h0, 32'hFFFF_FFFC, 2, 2'b00, 18'h0, 32'h0, -1, 32'hFFFF_FFFC, 1'b1);
    vecs[14] = mk(2'b00, 18'h0, 32'h0, -1, 2'b00, 18'h0, 32'h0, -1, 32'h0000_0000, 1'b0);
    vecs[15] = mk(2'b01, 18'h3FFFC, 32'h0, 0, 2'b00, 18'h0, 32'h0, -1, 32'hFFFF_FFFC, 1'b1);
    vecs[16] = mk(2'b00, 18'h0, 32'h0, -1, 2'b00, 18'h0, 32'h0, -1, 32'h0000_0000, 1'b0);
    vecs[17] = mk(2'b01, 18'h00010, 32'h0, 3, 2'b00, 18'h0, 32'h0, -1, 32'h0000_0010, 1'b1);
    vecs[18] = mk(2'b00, 18'h0, 32'h0, -1, 2'b00, 18'h0, 32'h0, -1, 32'h0000_0014, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_pc", pc, RESET_PC);
    checkOutput("reset_phase", 32'(phase), 32'(0));
    checkOutput("reset_done", 32'(instr_done), 32'(0));
    checkOutput("reset_ack", 32'(redir_ack), 32'(0));
    rst_n        = 1'b1;
    cur_pc       = RESET_PC;
    after_commit = 1'b0;

    for (int n = 0; n < NVEC; n++) applyStimulus(vecs[n]);

    // Stall: 2 clocks at phase 1 (fetch gated), then 5 clocks at phase 2 with
    // a redirect pulse that must be ignored.
    $display("[TB] stall sequence");
    sb.push_back('{cur_pc + 32'd4, 1'b0});
    tick();
    stall = 1'b1;
    #1;
    checkOutput("stall_fetch_gate", 32'(fetch_en), 32'(0));
    repeat (2) begin
      tick();
      checkOutput("stall_phase1", 32'(phase), 32'(1));
      checkOutput("stall_fetch1", 32'(fetch_en), 32'(0));
    end
    stall = 1'b0;
    #1;
    checkOutput("unstall_fetch", 32'(fetch_en), 32'(1));
    tick();
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) driveReq(2'b11, 18'h0, 32'h0000_0400);
      else        idleInputs();
      tick();
      checkOutput("stall_phase2", 32'(phase), 32'(2));
      checkOutput("stall_pc", pc, cur_pc);
      checkOutput("stall_fetch2", 32'(fetch_en), 32'(0));
      checkOutput("stall_done", 32'(instr_done), 32'(0));
      checkOutput("stall_ack", 32'(redir_ack), 32'(0));
    end
    idleInputs();
    stall = 1'b0;
    tick();
    checkOutput("post_stall_phase3", 32'(phase), 32'(3));
    tick();
    checkOutput("post_stall_phase0", 32'(phase), 32'(0));
    checkOutput("post_stall_pc", pc, cur_pc + 32'd4);
    checkOutput("post_stall_done", 32'(instr_done), 32'(1));
    cur_pc = cur_pc + 32'd4;

    // Reset at phase 2 with a redirect pending: it must be discarded.
    $display("[TB] reset with pending redirect");
    driveReq(2'b11, 18'h0, 32'h0000_0300);
    tick();
    idleInputs();
    tick();
    checkOutput("pre_reset_phase", 32'(phase), 32'(2));
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_pc", pc, RESET_PC);
    checkOutput("async_reset_phase", 32'(phase), 32'(0));
    tick();
    rst_n        = 1'b1;
    cur_pc       = RESET_PC;
    after_commit = 1'b0;
    applyStimulus(mk(2'b00, 18'h0, 32'h0, -1, 2'b00, 18'h0, 32'h0, -1,
                     RESET_PC + 32'd4, 1'b0));

    @(negedge clk);
    #1;
    checkOutput("sb_drained", 32'(sb.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
